// File: rtl/bsg_sipo_dynamic_lock_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : bsg_sipo_dynamic_lock_arbiter_pkg                                |
// | Purpose : Shared helpers for the dynamic-length SIPO lock arbiter slice.   |
// |           safe_clog2 sizes len/id fields so one-entry cases stay 1 bit.    |
// | Ports   : none                                                             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package bsg_sipo_dynamic_lock_arbiter_pkg;

  // ceil(log2(n)), but never below 1 so degenerate sizes still get a real bit.
  function automatic int safe_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_sipo_dynamic_lock_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : bsg_sipo_dynamic_lock_arbiter_if                               |
// | Purpose   : Bundles the requester-side beat handshake and the SIPO-side    |
// |             passthrough of the lock arbiter.                               |
// | Signals   : v_i/len_i/data_i  per-requester beat valid, last index, data   |
// |             ready_and_o       per-requester beat accepted                  |
// |             sipo_v_o/len_o/data_o  beat to SIPO, sipo_ready_and_i back     |
// |             grant_id_o        owner of the SIPO                            |
// | Modports  : slave  (arbiter side), master (requesters + SIPO side)         |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface bsg_sipo_dynamic_lock_arbiter_if
  import bsg_sipo_dynamic_lock_arbiter_pkg::*;
#(
  parameter int reqs_p  = 2,
  parameter int width_p = 8,
  parameter int els_p   = 4,
  localparam int lg_max_els_lp = safe_clog2(els_p),
  localparam int lg_reqs_lp    = safe_clog2(reqs_p)
);

  logic [reqs_p-1:0]               v_i;
  logic [reqs_p*lg_max_els_lp-1:0] len_i;
  logic [reqs_p*width_p-1:0]       data_i;
  logic [reqs_p-1:0]               ready_and_o;

  logic                            sipo_v_o;
  logic [lg_max_els_lp-1:0]        sipo_len_o;
  logic [width_p-1:0]              sipo_data_o;
  logic                            sipo_ready_and_i;
  logic [lg_reqs_lp-1:0]           grant_id_o;

  modport slave (
    input  v_i, len_i, data_i, sipo_ready_and_i,
    output ready_and_o, sipo_v_o, sipo_len_o, sipo_data_o, grant_id_o
  );

  modport master (
    output v_i, len_i, data_i, sipo_ready_and_i,
    input  ready_and_o, sipo_v_o, sipo_len_o, sipo_data_o, grant_id_o
  );

endinterface
`default_nettype wire

// File: rtl/bsg_arb_round_robin.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bsg_arb_round_robin                                              |
// | Purpose : Round-robin arbiter. Priority starts one past the last winner;   |
// |           the pointer only moves when yumi_i confirms the grant was used.  |
// | Ports   : clk_i, reset_i  clock, synchronous active-high reset             |
// |           reqs_i   width_p  requests                                       |
// |           grants_o width_p  one-hot grant (zero if no request)             |
// |           yumi_i   1        current grant consumed; advance pointer        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module bsg_arb_round_robin
  import bsg_sipo_dynamic_lock_arbiter_pkg::*;
#(
  parameter int width_p = 2,
  localparam int lg_width_lp = safe_clog2(width_p)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] reqs_i,
  output logic [width_p-1:0] grants_o,
  input  logic               yumi_i
);

  logic [lg_width_lp-1:0] last_q;
  logic [lg_width_lp-1:0] pick;
  logic                   found;

  // Two ascending passes: indices above the last winner first, then the
  // wrap-around half. The first request hit in that order wins.
  always_comb begin
    grants_o = '0;
    pick     = last_q;
    found    = 1'b0;
    for (int i = 0; i < width_p; i++) begin
      if (!found && (i > int'(last_q)) && reqs_i[i]) begin
        found       = 1'b1;
        grants_o[i] = 1'b1;
        pick        = lg_width_lp'(i);
      end
    end
    for (int i = 0; i < width_p; i++) begin
      if (!found && (i <= int'(last_q)) && reqs_i[i]) begin
        found       = 1'b1;
        grants_o[i] = 1'b1;
        pick        = lg_width_lp'(i);
      end
    end
  end

  // Reset to the top index so requester 0 has first priority.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_q <= lg_width_lp'(width_p - 1);
    end else if (yumi_i && found) begin
      last_q <= pick;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bsg_encode_one_hot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bsg_encode_one_hot                                               |
// | Purpose : Converts a one-hot vector to its binary index (zero if empty).   |
// | Ports   : i       width_p               one-hot input                      |
// |           addr_o  safe_clog2(width_p)   index of the set bit               |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module bsg_encode_one_hot
  import bsg_sipo_dynamic_lock_arbiter_pkg::*;
#(
  parameter int width_p = 2,
  localparam int lg_width_lp = safe_clog2(width_p)
) (
  input  logic [width_p-1:0]     i,
  output logic [lg_width_lp-1:0] addr_o
);

  // OR of indices is exact for a one-hot input and needs no priority chain.
  always_comb begin
    addr_o = '0;
    for (int k = 0; k < width_p; k++) begin
      if (i[k]) addr_o = addr_o | lg_width_lp'(k);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bsg_mux_one_hot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bsg_mux_one_hot                                                  |
// | Purpose : AND-OR multiplexer selecting one width_p field from a flat bus.  |
// |           An all-zero select yields zero.                                  |
// | Ports   : data_i        els_p*width_p  packed fields, field 0 in LSBs      |
// |           sel_one_hot_i els_p          one-hot (or zero) select            |
// |           data_o        width_p        selected field                      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module bsg_mux_one_hot #(
  parameter int width_p = 1,
  parameter int els_p   = 1
) (
  input  logic [els_p*width_p-1:0] data_i,
  input  logic [els_p-1:0]         sel_one_hot_i,
  output logic [width_p-1:0]       data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < els_p; i++) begin
      data_o = data_o | (data_i[i*width_p +: width_p] & {width_p{sel_one_hot_i[i]}});
    end
  end

endmodule
`default_nettype wire

// File: rtl/bsg_sipo_dynamic_lock_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bsg_sipo_dynamic_lock_arbiter                                    |
// | Purpose : Shares one dynamic-length SIPO between reqs_p requesters.        |
// |           Round-robin grant, locked to the winner until the last beat of   |
// |           its message (index len_i, sampled on the first beat) is taken,   |
// |           so messages never interleave. Forward path is combinational.     |
// | Ports   : clk_i     clock                                                  |
// |           reset_i   synchronous active-high reset                          |
// |           bus       slave modport: v_i, len_i, data_i, ready_and_o,        |
// |                     sipo_v_o, sipo_len_o, sipo_data_o, sipo_ready_and_i,   |
// |                     grant_id_o                                             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module bsg_sipo_dynamic_lock_arbiter
  import bsg_sipo_dynamic_lock_arbiter_pkg::*;
#(
  parameter int reqs_p  = 2,
  parameter int width_p = 8,
  parameter int els_p   = 4,
  localparam int lg_max_els_lp = safe_clog2(els_p),
  localparam int lg_reqs_lp    = safe_clog2(reqs_p)
) (
  input logic                              clk_i,
  input logic                              reset_i,
  bsg_sipo_dynamic_lock_arbiter_if.slave   bus
);

  localparam logic [lg_max_els_lp:0] c_max_len_idx = (lg_max_els_lp + 1)'(els_p - 1);

  typedef enum logic [0:0] {
    e_idle = 1'b0,
    e_lock = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [lg_max_els_lp-1:0] cnt_q, cnt_d;
  logic [lg_max_els_lp-1:0] len_q, len_d;
  logic [lg_reqs_lp-1:0]    owner_q, owner_d;

  logic [reqs_p-1:0]        owner_oh;
  logic [reqs_p-1:0]        arb_reqs;
  logic [reqs_p-1:0]        arb_grants;
  logic [reqs_p-1:0]        grant;
  logic [lg_reqs_lp-1:0]    grant_id;
  logic [lg_max_els_lp-1:0] mux_len;
  logic [width_p-1:0]       mux_data;
  logic                     sipo_v;
  logic                     xfer;
  logic                     last_beat;
  logic                     msg_done;

  for (genvar g = 0; g < reqs_p; g++) begin : g_owner_oh
    assign owner_oh[g] = (owner_q == lg_reqs_lp'(g));
  end

  // While locked only the owner is offered to the arbiter, so on the
  // completing beat its grant is the owner and the pointer lands there.
  assign arb_reqs = (state_q == e_lock) ? (owner_oh & bus.v_i) : bus.v_i;

  bsg_arb_round_robin #(
    .width_p (reqs_p)
  ) u_rr (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .reqs_i   (arb_reqs),
    .grants_o (arb_grants),
    .yumi_i   (msg_done)
  );

  // The owner keeps the grant through bubbles, even with v_i low.
  assign grant = (state_q == e_lock) ? owner_oh : arb_grants;

  bsg_mux_one_hot #(
    .width_p (lg_max_els_lp),
    .els_p   (reqs_p)
  ) u_len_mux (
    .data_i        (bus.len_i),
    .sel_one_hot_i (grant),
    .data_o        (mux_len)
  );

  bsg_mux_one_hot #(
    .width_p (width_p),
    .els_p   (reqs_p)
  ) u_data_mux (
    .data_i        (bus.data_i),
    .sel_one_hot_i (grant),
    .data_o        (mux_data)
  );

  bsg_encode_one_hot #(
    .width_p (reqs_p)
  ) u_enc (
    .i      (grant),
    .addr_o (grant_id)
  );

  assign sipo_v    = |(bus.v_i & grant);
  assign xfer      = sipo_v & bus.sipo_ready_and_i;
  assign last_beat = (state_q == e_lock) ? (cnt_q == len_q) : (mux_len == '0);
  assign msg_done  = xfer & last_beat;

  assign bus.ready_and_o = grant & {reqs_p{bus.sipo_ready_and_i}};
  assign bus.sipo_v_o    = sipo_v;
  assign bus.sipo_data_o = mux_data;
  assign bus.sipo_len_o  = (state_q == e_lock) ? len_q : mux_len;
  assign bus.grant_id_o  = grant_id;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    owner_d = owner_q;
    case (state_q)
      e_idle: begin
        // A single-beat message completes here; longer ones take the lock.
        if (xfer && (mux_len != '0)) begin
          state_d = e_lock;
          owner_d = grant_id;
          len_d   = mux_len;
          cnt_d   = lg_max_els_lp'(1);
        end
      end
      e_lock: begin
        if (xfer) begin
          if (cnt_q == len_q) begin
            state_d = e_idle;
          end else begin
            cnt_d = cnt_q + lg_max_els_lp'(1);
          end
        end
      end
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      cnt_q   <= '0;
      len_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      owner_q <= owner_d;
    end
  end

  // A message longer than the SIPO depth cannot be assembled.
  a_len_legal : assert property (@(posedge clk_i) disable iff (reset_i)
    ((state_q == e_idle) && sipo_v) |-> ({1'b0, mux_len} <= c_max_len_idx));

endmodule
`default_nettype wire
